// File: rtl/n64_joybus_engine.sv
// Joybus bit engine: sends one 8-bit command on the open-drain line, then captures the controller reply.
// Latency: data_line_oe rises the cycle after an accepted start; the command takes 33 us up to stop release.
// Backpressure: none; start is ignored while busy or during the done cycle, and one transaction runs at a time.
//
// Ports:
//   PCLK, PRESERN          clock (rising edge) and asynchronous active-low reset
//   start, cmd[7:0]        request pulse and the command byte latched when it is accepted
//   data_line_in           raw pad level, asynchronous to PCLK
//   data_line_oe           1 pulls the line low, 0 releases it
//   busy, done             transaction in flight / one-cycle end-of-transaction pulse
//   resp[31:0]             last good response, right-justified in [RESP_BITS-1:0]
//   timeout_err            1 if the last transaction was aborted for lack of line activity
module n64_joybus_engine #(
  parameter int US_CYCLES  = 100,
  parameter int RESP_BITS  = 32,
  parameter int TIMEOUT_US = 200
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic        data_line_in,
  output logic        data_line_oe,
  output logic        busy,
  output logic        done,
  output logic [31:0] resp,
  output logic        timeout_err
);

  localparam int TO_CYC  = TIMEOUT_US * US_CYCLES;
  localparam int MAX_CYC = (TO_CYC > 3 * US_CYCLES) ? TO_CYC : 3 * US_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int BC_W    = $clog2(RESP_BITS + 1);

  localparam logic [CNT_W-1:0] CYC_1US = CNT_W'(US_CYCLES);
  localparam logic [CNT_W-1:0] CYC_2US = CNT_W'(2 * US_CYCLES);
  localparam logic [CNT_W-1:0] CYC_3US = CNT_W'(3 * US_CYCLES);
  localparam logic [CNT_W-1:0] CYC_TO  = CNT_W'(TO_CYC);
  localparam logic [BC_W-1:0]  NBITS   = BC_W'(RESP_BITS);

  typedef enum logic [2:0] {
    IDLE, TX_LOW, TX_HIGH, TX_STOP, RX_WAIT_FALL, RX_SAMPLE, RX_WAIT_HIGH, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0]      shift_q, shift_d;
  logic [31:0]      resp_q, resp_d;
  logic [1:0]       sync_q, sync_d;
  logic             sync_prev_q, sync_prev_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             terr_q, terr_d;

  logic             line_s;
  logic             fall;
  logic             tx_bit;
  logic [CNT_W-1:0] low_len, high_len;

  assign line_s   = sync_q[1];
  assign fall     = sync_prev_q & ~line_s;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign tx_bit   = cmd_q[tx_idx_q];
  assign low_len  = tx_bit ? CYC_1US : CYC_3US;
  assign high_len = tx_bit ? CYC_3US : CYC_1US;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    tx_idx_d    = tx_idx_q;
    cmd_d       = cmd_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    resp_d      = resp_q;
    terr_d      = terr_q;
    sync_d      = {sync_q[0], data_line_in};
    sync_prev_d = line_s;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          cmd_d     = cmd;
          terr_d    = 1'b0;
          tx_idx_d  = 3'd7;
          bit_cnt_d = '0;
          shift_d   = '0;
          state_d   = TX_LOW;
        end
      end
      TX_LOW: begin
        if (cnt_inc == low_len) begin
          cnt_d   = '0;
          state_d = TX_HIGH;
        end
      end
      TX_HIGH: begin
        if (cnt_inc == high_len) begin
          cnt_d = '0;
          if (tx_idx_q == 3'd0) begin
            state_d = TX_STOP;
          end else begin
            tx_idx_d = tx_idx_q - 3'd1;
            state_d  = TX_LOW;
          end
        end
      end
      TX_STOP: begin
        // Release straight after the low half; the stop bit's high time overlaps the reply wait.
        if (cnt_inc == CYC_1US) begin
          cnt_d   = '0;
          state_d = RX_WAIT_FALL;
        end
      end
      RX_WAIT_FALL: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = RX_SAMPLE;
        end else if (cnt_inc >= CYC_TO) begin
          terr_d  = 1'b1;
          state_d = DONE;
        end
      end
      RX_SAMPLE: begin
        // The counter keeps running from the falling edge so the timeout spans the whole bit.
        if (cnt_inc == CYC_2US) begin
          shift_d   = {shift_q[30:0], line_s};
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          state_d   = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        if (line_s) begin
          if (bit_cnt_q == NBITS) begin
            resp_d  = shift_q;
            state_d = DONE;
          end else begin
            state_d = RX_WAIT_FALL;
          end
        end else if (cnt_inc >= CYC_TO) begin
          terr_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so the pad drive is glitch-free.
    oe_d   = (state_d == TX_LOW) || (state_d == TX_STOP);
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_idx_q    <= '0;
      cmd_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      resp_q      <= '0;
      sync_q      <= 2'b11;  // idle line level, so leaving reset never looks like a falling edge
      sync_prev_q <= 1'b1;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_idx_q    <= tx_idx_d;
      cmd_q       <= cmd_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      resp_q      <= resp_d;
      sync_q      <= sync_d;
      sync_prev_q <= sync_prev_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      terr_q      <= terr_d;
    end
  end

  assign data_line_oe = oe_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign resp         = resp_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_n64_joybus_engine.sv
// Bench for n64_joybus_engine: two instances (32-bit and 16-bit replies) share one stimulus driver.
// A controller model answers on the wired-AND line; expected results are queued at issue time.
// A monitor pops the queue on every done pulse and compares the response, status and timing.
module tb_n64_joybus_engine;

  localparam int US    = 4;
  localparam int TO_US = 10;
  localparam int TXC   = 33 * US;  // cycles from first low to stop-bit release

  typedef struct {
    logic [31:0] resp;
    logic        terr;
    int          lo;
    int          hi;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, start, sel, ctl_low;
  logic [7:0]  cmd;
  logic        start_a, start_b, line_a, line_b;
  logic        oe_a, oe_b, busy_a, busy_b, done_a, done_b, terr_a, terr_b;
  logic [31:0] resp_a, resp_b;
  logic        oe, busy, done;
  logic [31:0] resp;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] lr [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign line_a  = ~(oe_a | (ctl_low & ~sel));
  assign line_b  = ~(oe_b | (ctl_low & sel));
  assign oe      = sel ? oe_b : oe_a;
  assign busy    = sel ? busy_b : busy_a;
  assign done    = sel ? done_b : done_a;
  assign resp    = sel ? resp_b : resp_a;

  n64_joybus_engine #(.US_CYCLES(US), .RESP_BITS(32), .TIMEOUT_US(TO_US)) u_a (
    .PCLK(clk), .PRESERN(rst_n), .start(start_a), .cmd(cmd), .data_line_in(line_a),
    .data_line_oe(oe_a), .busy(busy_a), .done(done_a), .resp(resp_a), .timeout_err(terr_a)
  );

  n64_joybus_engine #(.US_CYCLES(US), .RESP_BITS(16), .TIMEOUT_US(TO_US)) u_b (
    .PCLK(clk), .PRESERN(rst_n), .start(start_b), .cmd(cmd), .data_line_in(line_b),
    .data_line_oe(oe_b), .busy(busy_b), .done(done_b), .resp(resp_b), .timeout_err(terr_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Line drive expected k cycles after the start is accepted: per bit, a '1' is
  // 1 us low then 3 us high, a '0' is 3 us low then 1 us high; then a 1 us low stop.
  function automatic logic exp_oe(input logic [7:0] c, input int k);
    int bitn, pos, low_us;
    if (k >= TXC) return 1'b0;
    if (k >= 32 * US) return 1'b1;
    bitn   = k / (4 * US);
    pos    = k % (4 * US);
    low_us = c[7 - bitn] ? 1 : 3;
    return pos < low_us * US;
  endfunction

  task automatic mon_check(input bit s, input logic [31:0] r, input logic te, input logic bz);
    exp_t e;
    if ((s && q_b.size() == 0) || (!s && q_a.size() == 0)) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_done inst=%0d: resp %h with no transaction outstanding", s, r);
    end else begin
      if (s) e = q_b.pop_front();
      else   e = q_a.pop_front();
      chk("resp", r, e.resp);
      chk("timeout_err", {31'b0, te}, {31'b0, e.terr});
      chk("busy_at_done", {31'b0, bz}, 32'd0);
      n_vec++;
      if (cyc < e.lo || cyc > e.hi) begin
        n_err++;
        $display("FAIL done_time: done at cycle %0d, expected %0d..%0d", cyc, e.lo, e.hi);
      end
    end
  endtask

  always @(negedge clk) begin
    if (done_a) mon_check(1'b0, resp_a, terr_a, busy_a);
    if (done_b) mon_check(1'b1, resp_b, terr_b, busy_b);
  end

  // mode 0: controller replies with data; mode 1: silence (timeout); mode 2: reset during reply bit 10.
  // poke: extra start pulses (cmd 0xFF) during TX, during RX and in the done cycle, all to be ignored.
  task automatic run_txn(input logic [7:0] c, input logic [31:0] data, input int mode, input bit poke);
    int          n, gap, c0, f, lowc, wt, bad;
    logic [TXC:0] wav_exp, wav_act;
    bit          busy_ok;
    exp_t        e;
    n   = sel ? 16 : 32;
    gap = US * $urandom_range(1, 6);
    @(negedge clk);
    c0    = cyc;
    start = 1'b1;
    cmd   = c;
    if (mode == 0) begin
      f      = c0 + TXC + 1 + gap + 4 * US * (n - 1);  // last bit's falling edge
      e.resp = data;
      e.terr = 1'b0;
      e.lo   = f + (data[0] ? US : 3 * US) + 1;
      e.hi   = f + 4 * US + 4;
      lr[sel] = data;
    end else begin
      e.resp = lr[sel];
      e.terr = 1'b1;
      e.lo   = c0 + 1 + TXC + TO_US * US;
      e.hi   = e.lo;
    end
    if (mode != 2) begin
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
    end

    busy_ok = 1'b1;
    for (int k = 0; k <= TXC; k++) begin
      @(negedge clk);
      wav_act[k] = oe;
      wav_exp[k] = exp_oe(c, k);
      if (!busy) busy_ok = 1'b0;
      if (k == 0) start = 1'b0;
      if (poke && k == 53) begin start = 1'b1; cmd = 8'hFF; end
      if (poke && k == 54) start = 1'b0;
    end
    n_vec++;
    if (wav_act !== wav_exp) begin
      n_err++;
      bad = -1;
      for (int j = TXC; j >= 0; j--) if (wav_act[j] !== wav_exp[j]) bad = j;
      $display("FAIL tx_wave cmd=%h: first bad cycle %0d oe=%b, expected %b", c, bad, wav_act[bad], wav_exp[bad]);
    end
    chk("busy_during_tx", {31'b0, busy_ok}, 32'd1);

    if (mode == 1) begin
      for (wt = 0; wt < 2000 && !done; wt++) @(negedge clk);
    end else begin
      repeat (gap) @(negedge clk);
      for (int i = 0; i < n; i++) begin
        lowc = data[n - 1 - i] ? US : 3 * US;
        for (int m = 0; m < ((i == n - 1) ? lowc + 1 : 4 * US); m++) begin
          ctl_low = (m < lowc);
          if (mode == 2 && i == 10 && m == 0) begin
            rst_n = 1'b0;
            #1;
            chk("rst_oe", {31'b0, oe}, 32'd0);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_resp", resp, 32'd0);
            ctl_low = 1'b0;
            lr[0] = '0;
            lr[1] = '0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            return;
          end
          if (poke && i == 5 && m == 2) begin start = 1'b1; cmd = 8'hFF; end
          if (poke && i == 5 && m == 3) start = 1'b0;
          if (!(i == n - 1 && m == lowc)) @(negedge clk);
        end
      end
      for (wt = 0; wt < 2000 && !done; wt++) @(negedge clk);
    end
    chk("done_seen", {31'b0, done}, 32'd1);
    if (poke) begin
      start = 1'b1;
      cmd   = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_done_ignored", {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    sel     = 1'b0;
    ctl_low = 1'b0;
    cmd     = 8'h00;
    lr[0]   = '0;
    lr[1]   = '0;
    repeat (3) @(negedge clk);
    chk("reset_oe",   {30'b0, oe_a, oe_b}, 32'd0);
    chk("reset_busy", {30'b0, busy_a, busy_b}, 32'd0);
    chk("reset_done", {30'b0, done_a, done_b}, 32'd0);
    chk("reset_terr", {30'b0, terr_a, terr_b}, 32'd0);
    chk("reset_resp_a", resp_a, 32'd0);
    chk("reset_resp_b", resp_b, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(8'h01, 32'hA5C3_0F81, 0, 1'b1);
    run_txn(8'($urandom), 32'd0, 1, 1'b0);
    for (int t = 0; t < 6; t++)
      run_txn(8'($urandom), $urandom, ($urandom_range(0, 3) == 0) ? 1 : 0, t == 2);
    run_txn(8'($urandom), $urandom | 32'h1, 0, 1'b0);
    run_txn(8'($urandom), $urandom, 2, 1'b0);
    run_txn(8'($urandom), $urandom, 0, 1'b0);

    sel = 1'b1;
    run_txn(8'($urandom), 32'h0000_1234, 0, 1'b0);
    run_txn(8'($urandom), 32'd0, 1, 1'b0);
    run_txn(8'($urandom), {16'h0, 16'($urandom)}, 0, 1'b1);

    repeat (20) @(negedge clk);
    chk("pending_a", q_a.size(), 32'd0);
    chk("pending_b", q_b.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
